varredura_display: RTL and testbench
====================================

# varredura_display

Scan controller for the four-digit seven-segment display. It generates the 2-bit digit selector that drives the downstream digit mux: 00 units, 01 tens, 10 agro-default, 11 state. It also generates the matching active-low anode enables, with a blanking interval between digits to suppress ghosting. Digits can be skipped through a mask, and a frame-end pulse lets upstream logic update displayed values without tearing.

## Interface
Parameters:
- DIV, 8: clock cycles per digit slot (blanking + display); DIV ≥ 2
- BLANK, 2: dead-time cycles at the start of each slot, all anodes off; 0 ≤ BLANK < DIV

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- habilita  in  1  scan enable, sampled at slot boundaries and in OCIOSO
- mascara  in  4  digit enable mask, bit i enables selector value i; sampled at slot boundaries
- seletor  out  2  digit index to the digit mux
- anodos  out  4  active-low digit enables; bit i corresponds to seletor value i
- fim_quadro  out  1  one-cycle pulse marking the start of a new frame

All outputs are registered. Reset is asynchronous and active-high. A single clock domain is used.

## Operation
- Reset values: seletor=00, anodos=1111, fim_quadro=0, state OCIOSO, slot counter=0.
- States:
  - OCIOSO: idle, anodes off.
  - APAGADO: blanking, anodes off, seletor already pointing at the new digit.
  - EXIBE: display, anodos[seletor]=0 and the other bits are 1.
- OCIOSO:
  - If habilita=1 and mascara≠0, seletor ← lowest enabled index.
  - Go to APAGADO, or straight to EXIBE when BLANK=0.
  - Counter ← 0.
- APAGADO: count BLANK cycles, then go to EXIBE.
- EXIBE: count DIV−BLANK cycles. On the last cycle:
  - If habilita=0 or mascara=0: go to OCIOSO, anodos ← 1111, seletor held.
  - Otherwise: seletor ← next enabled index strictly after the current one, cyclic 3→0. Go to APAGADO, or EXIBE when BLANK=0.
- Next-enabled search wraps. If only one digit is enabled, the next index equals the current index and the slot repeats, still including blanking.
- fim_quadro is asserted during the first cycle of a slot whose index is ≤ the previous slot's index (wrap). It is also asserted during the first slot after leaving OCIOSO.
- Changes to mascara or habilita in the middle of a slot do not affect the current slot. The slot always completes its full DIV cycles.
- Clearing the currently displayed digit's mask bit only takes effect at the slot boundary.
- Reset mid-slot: all outputs return to their reset values immediately, asynchronously.

## Timing
- Slot period is exactly DIV cycles from slot entry to the next slot entry.
- Frame period is DIV × popcount(mascara).
- Start latency: habilita seen high in OCIOSO at edge t gives seletor valid at t+1 and the anode low at t+1+BLANK.
- Stop latency: at most DIV cycles. Anodes go to 1111 on the edge that closes the current slot.
- seletor changes only on the edge entering a slot. The anode for a digit never goes low in the same cycle seletor changes, unless BLANK=0.
- Counter width: clog2(DIV). The counter resets to 0 at every state entry.

## Structure
- Shared package display_pkg holds:
  - the state enum (OCIOSO, APAGADO, EXIBE);
  - digit index constants DIG_UNID=0, DIG_DEZ=1, DIG_AGRO=2, DIG_ESTADO=3;
  - NUM_DIG=4.
- Combinational sub-module proximo_digito: inputs current index (2 bits) and mascara (4 bits). Outputs:
  - the next enabled index, cyclic, strictly after the current one;
  - a wrap flag (next ≤ current);
  - a nenhum flag (mascara=0).
- The top level holds the FSM, the slot counter and the output registers.

## Test plan
- Full scan: DIV=8, BLANK=2, mascara=1111, habilita=1 from reset.
  - Expect seletor sequence 0,1,2,3,0… with each value held 8 cycles.
  - anodos pattern for each digit i: 1111 for 2 cycles, then bit i=0 for 6 cycles.
  - fim_quadro pulses every 32 cycles, coinciding with seletor←0.
- Masked skip: mascara=0101.
  - Expect seletor 0,2,0,2 with each value held 8 cycles.
  - Anode enables 1110 and 1011 only.
  - fim_quadro every 16 cycles.
- Single digit: mascara=1000.
  - Expect seletor constant 3.
  - anodos alternates 1111 (2 cycles) and 0111 (6 cycles).
  - fim_quadro every 8 cycles.
- Stop and mask zero: drop habilita in cycle 3 of an EXIBE slot.
  - Expect the slot to complete, then anodos=1111 and OCIOSO.
  - Setting mascara=0000 with habilita=1 must also keep OCIOSO with anodes off.
- Async reset mid-EXIBE (seletor=2, anodos=1011): assert reset between clock edges.
  - Expect seletor=00, anodos=1111, fim_quadro=0 immediately, without waiting for a clock edge.
  - After reset is released, expect a restart from the lowest enabled digit, with fim_quadro asserted.
- BLANK=0 variant, DIV=4, mascara=1111: expect no 1111 cycles between digits, and anodos rotates 1110→1101→1011→0111 every 4 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scan logic.
//   - estado_t    : scan controller states (OCIOSO, APAGADO, EXIBE)
//   - DIG_*       : digit selector values seen by the downstream digit mux
//   - NUM_DIG     : number of digits on the display
//   - anodo_ativo : active-low anode pattern with a single digit enabled
package display_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,  // idle, all anodes off
        APAGADO = 2'd1,  // blanking at the start of a slot
        EXIBE   = 2'd2   // selected digit lit
    } estado_t;

    localparam int NUM_DIG = 4;

    localparam logic [1:0] DIG_UNID   = 2'd0;
    localparam logic [1:0] DIG_DEZ    = 2'd1;
    localparam logic [1:0] DIG_AGRO   = 2'd2;
    localparam logic [1:0] DIG_ESTADO = 2'd3;

    // Active-low: only bit idx is 0.
    function automatic logic [3:0] anodo_ativo(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/proximo_digito.sv
// Combinational search for the next enabled digit.
// Ports:
//   atual   in  2  current digit index
//   mascara in  4  digit enable mask, bit i enables index i
//   proximo out 2  first enabled index strictly after atual, wrapping 3 -> 0;
//                  equals atual when atual is the only enabled digit
//   volta   out 1  wrap flag, proximo <= atual
//   nenhum  out 1  no digit enabled (mascara == 0)
module proximo_digito
    import display_pkg::*;
(
    input  logic [1:0] atual,
    input  logic [3:0] mascara,
    output logic [1:0] proximo,
    output logic       volta,
    output logic       nenhum
);

    logic       achou;
    logic [1:0] cand;

    // Walk atual+1 .. atual+4; the last candidate is atual itself, which
    // covers the single-digit case.
    always_comb begin
        proximo = atual;
        achou   = 1'b0;
        cand    = atual;
        for (int k = 1; k <= NUM_DIG; k++) begin
            cand = atual + 2'(k);
            if (!achou && mascara[cand]) begin
                proximo = cand;
                achou   = 1'b1;
            end
        end
    end

    assign volta  = (proximo <= atual);
    assign nenhum = (mascara == 4'b0000);

endmodule

// File: rtl/varredura_display.sv
// Scan controller for the four-digit seven-segment display.
// Each enabled digit gets a slot of DIV cycles: BLANK cycles with all anodes
// off (seletor already pointing at the new digit), then DIV-BLANK cycles with
// that digit's anode driven low.
// Ports:
//   clock      in  1  system clock, rising edge
//   reset      in  1  asynchronous, active-high
//   habilita   in  1  scan enable, sampled at slot boundaries and when idle
//   mascara    in  4  digit enable mask, sampled at slot boundaries
//   seletor    out 2  digit index to the digit mux
//   anodos     out 4  active-low digit enables, bit i <-> seletor value i
//   fim_quadro out 1  one-cycle pulse in the first cycle of a new frame
module varredura_display
    import display_pkg::*;
#(
    parameter int unsigned DIV   = 8,  // cycles per digit slot, >= 2
    parameter int unsigned BLANK = 2   // blanking cycles per slot, < DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] mascara,
    output logic [1:0] seletor,
    output logic [3:0] anodos,
    output logic       fim_quadro
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    // Last counter value in each phase of the slot.
    localparam logic [CW-1:0] ULT_APAGADO = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [CW-1:0] ULT_EXIBE   = CW'(DIV - BLANK - 1);

    // State entered when a new slot starts.
    localparam estado_t ENTRADA_SLOT = (BLANK == 0) ? EXIBE : APAGADO;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [1:0]    seletor_q, seletor_d;
    logic [3:0]    anodos_q, anodos_d;
    logic          fim_q, fim_d;

    logic [1:0] busca_atual;
    logic [1:0] proximo;
    logic       volta;
    logic       nenhum;
    logic       inicia;
    logic       entra_slot;

    // From idle, searching after index 3 yields the lowest enabled index.
    assign busca_atual = (estado_q == OCIOSO) ? DIG_ESTADO : seletor_q;

    proximo_digito u_proximo_digito (
        .atual   (busca_atual),
        .mascara (mascara),
        .proximo (proximo),
        .volta   (volta),
        .nenhum  (nenhum)
    );

    assign inicia = habilita && !nenhum;

    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        seletor_d  = seletor_q;
        entra_slot = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                cont_d = '0;
                if (inicia) begin
                    seletor_d  = proximo;
                    entra_slot = 1'b1;
                    estado_d   = ENTRADA_SLOT;
                end
            end
            APAGADO: begin
                if (cont_q == ULT_APAGADO) begin
                    estado_d = EXIBE;
                    cont_d   = '0;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            EXIBE: begin
                if (cont_q == ULT_EXIBE) begin
                    cont_d = '0;
                    if (inicia) begin
                        seletor_d  = proximo;
                        entra_slot = 1'b1;
                        estado_d   = ENTRADA_SLOT;
                    end else begin
                        // Stop: seletor is held, anodes go off on this edge.
                        estado_d = OCIOSO;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
        endcase

        // A frame starts on a wrap or on the first slot after idle.
        fim_d    = entra_slot && ((estado_q == OCIOSO) || volta);
        anodos_d = (estado_d == EXIBE) ? anodo_ativo(seletor_d) : 4'b1111;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            seletor_q <= DIG_UNID;
            anodos_q  <= 4'b1111;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            seletor_q <= seletor_d;
            anodos_q  <= anodos_d;
            fim_q     <= fim_d;
        end
    end

    assign seletor    = seletor_q;
    assign anodos     = anodos_q;
    assign fim_quadro = fim_q;

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display: instance a uses DIV=8/BLANK=2,
// instance b uses DIV=4/BLANK=0; both share clock and inputs.
module tb_varredura_display;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [3:0] mascara;

    logic [1:0] sel_a, sel_b;
    logic [3:0] an_a, an_b;
    logic       fim_a, fim_b;

    int checks   = 0;
    int failures = 0;

    varredura_display #(.DIV(8), .BLANK(2)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .mascara    (mascara),
        .seletor    (sel_a),
        .anodos     (an_a),
        .fim_quadro (fim_a)
    );

    varredura_display #(.DIV(4), .BLANK(0)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .mascara    (mascara),
        .seletor    (sel_b),
        .anodos     (an_b),
        .fim_quadro (fim_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obtido,
                            input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
        end
    endtask

    // Expected outputs n cycles after the start edge of a continuous scan.
    function automatic void modelo(input int div, input int blank, input int n,
                                   input logic [3:0] masc, output logic [1:0] sel,
                                   output logic [3:0] an, output logic fim);
        int lista[4];
        int len;
        int idx;
        int ph;
        len = 0;
        for (int i = 0; i < 4; i++) begin
            lista[i] = 0;
            if (masc[i]) begin
                lista[len] = i;
                len++;
            end
        end
        idx = (n / div) % len;
        ph  = n % div;
        sel = 2'(lista[idx]);
        an  = (ph < blank) ? 4'b1111 : ~(4'b0001 << sel);
        fim = (ph == 0) && (idx == 0);
    endfunction

    task automatic confere_ciclo(input string tst, input int n, input logic [3:0] masc);
        logic [1:0] s;
        logic [3:0] a;
        logic       f;
        modelo(8, 2, n, masc, s, a, f);
        verifica($sformatf("%s a.sel n=%0d", tst, n), 32'(sel_a), 32'(s));
        verifica($sformatf("%s a.an n=%0d", tst, n), 32'(an_a), 32'(a));
        verifica($sformatf("%s a.fim n=%0d", tst, n), 32'(fim_a), 32'(f));
        modelo(4, 0, n, masc, s, a, f);
        verifica($sformatf("%s b.sel n=%0d", tst, n), 32'(sel_b), 32'(s));
        verifica($sformatf("%s b.an n=%0d", tst, n), 32'(an_b), 32'(a));
        verifica($sformatf("%s b.fim n=%0d", tst, n), 32'(fim_b), 32'(f));
    endtask

    // Optionally release reset, then check cycles n_ini .. n_fim-1.
    task automatic rodar(input string tst, input logic [3:0] masc, input int n_ini,
                         input int n_fim, input bit liberar);
        mascara  = masc;
        habilita = 1'b1;
        if (liberar) begin
            @(negedge clock);
            reset = 1'b0;
        end
        for (int n = n_ini; n < n_fim; n++) begin
            @(posedge clock);
            #1;
            confere_ciclo(tst, n, masc);
        end
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic aplica_reset(input string tst);
        #2;
        reset = 1'b1;
        #1;
        verifica({tst, " rst a.sel"}, 32'(sel_a), 32'd0);
        verifica({tst, " rst a.an"}, 32'(an_a), 32'hF);
        verifica({tst, " rst a.fim"}, 32'(fim_a), 32'd0);
        verifica({tst, " rst b.sel"}, 32'(sel_b), 32'd0);
        verifica({tst, " rst b.an"}, 32'(an_b), 32'hF);
        verifica({tst, " rst b.fim"}, 32'(fim_b), 32'd0);
    endtask

    task automatic confere_ocioso(input string tst, input logic [1:0] sa,
                                  input logic [1:0] sb);
        verifica({tst, " a.sel"}, 32'(sel_a), 32'(sa));
        verifica({tst, " a.an"}, 32'(an_a), 32'hF);
        verifica({tst, " a.fim"}, 32'(fim_a), 32'd0);
        verifica({tst, " b.sel"}, 32'(sel_b), 32'(sb));
        verifica({tst, " b.an"}, 32'(an_b), 32'hF);
        verifica({tst, " b.fim"}, 32'(fim_b), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        habilita = 1'b0;
        mascara  = 4'b0000;
        #2;
        confere_ocioso("inicio", 2'd0, 2'd0);

        // Full scan, all digits.
        rodar("cheio", 4'b1111, 0, 40, 1'b1);

        // Skip digits 1 and 3; stop mid-EXIBE on digit 2 and reset there.
        aplica_reset("pre_masc");
        rodar("masc", 4'b0101, 0, 13, 1'b1);
        verifica("meio sel=2", 32'(sel_a), 32'd2);
        verifica("meio an=1011", 32'(an_a), 32'hB);
        aplica_reset("meio_exibe");
        rodar("reinicio", 4'b0101, 0, 32, 1'b1);

        // Single digit.
        aplica_reset("pre_unico");
        rodar("unico", 4'b1000, 0, 24, 1'b1);

        // Drop habilita in EXIBE cycle 3 of digit 1 (a) / start of digit 3 (b).
        aplica_reset("pre_parada");
        rodar("parada", 4'b1111, 0, 13, 1'b1);
        habilita = 1'b0;
        for (int n = 13; n < 16; n++) begin
            @(posedge clock);
            #1;
            confere_ciclo("conclui", n, 4'b1111);
        end
        for (int n = 16; n < 24; n++) begin
            @(posedge clock);
            #1;
            confere_ocioso($sformatf("ocioso n=%0d", n), 2'd1, 2'd3);
        end

        // Enabled but empty mask: remains idle.
        habilita = 1'b1;
        mascara  = 4'b0000;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock);
            #1;
            confere_ocioso($sformatf("masc0 n=%0d", n), 2'd1, 2'd3);
        end

        // Restart from idle without reset: lowest enabled digit, fim asserted.
        rodar("retoma", 4'b0110, 0, 20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
